uart_cmd_rx: RTL and testbench

Serial command front end for the motion controller. Samples the `rxd` line, deserialises 8N1 UART bytes, assembles fixed-length register-write packets, checks them, and presents each good write to the motion register file that loads `acc_profile_gen` / `motor_step_gen`. It sits directly between the board `rxd` pin and the register file inside `top`.

---
 rtl/uart_cmd_rx_pkg.sv | 37 +++
 rtl/uart_cmd_rx_byte_rx.sv | 119 +++++++++++
 rtl/uart_cmd_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_rx_pkg.sv
// uart_cmd_rx_pkg
// Shared definitions for the serial command front end: packet framing
// constants, receiver and parser state encodings, the motion register
// address map used by top, and the checksum fold helper.
package uart_cmd_rx_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         PKT_DATA_BYTES = 4;

  // Motion register file address map.
  localparam logic [7:0] REG_ACC_TARGET  = 8'h00;
  localparam logic [7:0] REG_ACC_MAX_VEL = 8'h01;
  localparam logic [7:0] REG_ACC_ACCEL   = 8'h02;
  localparam logic [7:0] REG_STEP_PERIOD = 8'h03;
  localparam logic [7:0] REG_STEP_CTRL   = 8'h04;

  typedef enum logic [2:0] {
    P_HUNT,
    P_ADDR,
    P_DATA,
    P_CSUM,
    P_HOLD
  } parse_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_byte_rx.sv
// uart_byte_rx
// 8N1 UART byte receiver with 2-flop input synchroniser.
// Ports:
//   osc_clk    in   clock
//   rst        in   asynchronous active-low reset
//   rxd        in   asynchronous UART line, idles high
//   byte_valid out  1-cycle pulse, byte_data holds the received byte
//   byte_data  out  last received byte
//   frame_err  out  1-cycle pulse on a low stop bit
module uart_byte_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // prev_q is one stage behind sync2_q so a falling edge can be detected.
  always_ff @(posedge osc_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge osc_clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // Mid-bit re-check: a start bit that is already high again was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        // A broken frame leaves the line low; re-arm only once it returns high.
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// Assembles 7-byte register-write packets (A5, ADDR, D0..D3, CSUM) from the
// UART byte stream, checks the XOR checksum and presents good writes with a
// valid/ready handshake.
// Ports:
//   osc_clk      in   clock
//   rst          in   asynchronous active-low reset
//   rxd          in   UART line
//   wr_valid     out  checked write pending
//   wr_ready     in   register file accepts the write
//   wr_addr      out  register index
//   wr_data      out  register value (D0 in bits 7:0)
//   err_frame    out  pulse: bad stop bit
//   err_csum     out  pulse: checksum mismatch
//   err_overrun  out  pulse: byte dropped while a write is pending
//   err_timeout  out  pulse: packet abandoned after an inter-byte gap
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        osc_clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err_frame,
  output logic        err_csum,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int TMAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW   = $clog2(TMAX + 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .osc_clk    (osc_clk),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  parse_state_e state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [1:0]   lane_q, lane_d;
  logic [7:0]   csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic         wr_valid_q, wr_valid_d;
  logic         csum_err_q, csum_err_d;
  logic         ovr_q, ovr_d;
  logic         tmo_q, tmo_d;
  logic         in_pkt;

  always_ff @(posedge osc_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= P_HUNT;
      addr_q     <= '0;
      data_q     <= '0;
      lane_q     <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      wr_valid_q <= 1'b0;
      csum_err_q <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      lane_q     <= lane_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      wr_valid_q <= wr_valid_d;
      csum_err_q <= csum_err_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign in_pkt = (state_q == P_ADDR) || (state_q == P_DATA) || (state_q == P_CSUM);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    lane_d     = lane_q;
    csum_d     = csum_q;
    wr_valid_d = wr_valid_q;
    csum_err_d = 1'b0;
    ovr_d      = 1'b0;
    tmo_d      = 1'b0;
    timer_d    = in_pkt ? timer_q + 1'b1 : '0;
    if (byte_valid) timer_d = '0;

    case (state_q)
      P_HUNT: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = P_ADDR;
          csum_d  = '0;
        end
      end
      P_ADDR, P_DATA, P_CSUM: begin
        // Byte is checked before the timeout so a coincident byte wins.
        if (frame_err) begin
          state_d = P_HUNT;
          timer_d = '0;
        end else if (byte_valid) begin
          csum_d = csum_fold(csum_q, byte_data);
          case (state_q)
            P_ADDR: begin
              addr_d  = byte_data;
              lane_d  = '0;
              state_d = P_DATA;
            end
            P_DATA: begin
              data_d[{lane_q, 3'b000} +: 8] = byte_data;
              lane_d = lane_q + 1'b1;
              if (lane_q == 2'(PKT_DATA_BYTES - 1)) state_d = P_CSUM;
            end
            default: begin
              if (byte_data == csum_q) begin
                state_d    = P_HOLD;
                wr_valid_d = 1'b1;
              end else begin
                csum_err_d = 1'b1;
                state_d    = P_HUNT;
              end
            end
          endcase
        end else if (timer_q == TW'(TMAX)) begin
          tmo_d   = 1'b1;
          state_d = P_HUNT;
          timer_d = '0;
        end
      end
      P_HOLD: begin
        // A byte arriving with the handshake is handled as if already in HUNT.
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = P_HUNT;
          if (byte_valid && byte_data == SYNC_BYTE) begin
            state_d = P_ADDR;
            csum_d  = '0;
          end
        end else if (byte_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = P_HUNT;
    endcase
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign err_frame   = frame_err;
  assign err_csum    = csum_err_q;
  assign err_overrun = ovr_q;
  assign err_timeout = tmo_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  localparam int CPB = 8;
  localparam int EV_WR = 0, EV_FRAME = 1, EV_CSUM = 2, EV_OVR = 3, EV_TMO = 4;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_frame, err_csum, err_overrun, err_timeout;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .osc_clk     (clk),
    .rst         (rst),
    .rxd         (rxd),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .err_frame   (err_frame),
    .err_csum    (err_csum),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  function automatic logic [7:0] pkt_csum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  task automatic push(input int k, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every event the DUT presents is matched against the
  // oldest expected event.
  task automatic check_ev(input int k, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_WR && (e.addr != a || e.data != d))) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wr_valid && wr_ready) check_ev(EV_WR, wr_addr, wr_data);
      if (err_frame)            check_ev(EV_FRAME, 8'h00, 32'h0);
      if (err_csum)             check_ev(EV_CSUM, 8'h00, 32'h0);
      if (err_overrun)          check_ev(EV_OVR, 8'h00, 32'h0);
      if (err_timeout)          check_ev(EV_TMO, 8'h00, 32'h0);
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
    send_byte(cs);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (wr_valid) begin
        seen = 1;
        break;
      end
      tick(1);
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {wr_valid, err_frame, err_csum, err_overrun, err_timeout, wr_addr, wr_data},
        64'h0);
  endtask

  initial begin
    int bad;
    logic [31:0] d1, d2, d3;
    d1 = 32'h1234_5678;
    d2 = 32'hDEAD_BEEF;
    d3 = 32'h0000_00FF;
    rst = 1'b0;
    rxd = 1'b1;
    wr_ready = 1'b0;
    tick(3);
    chk_idle_outputs("reset_outputs");
    rst = 1'b1;
    tick(10);

    // Good packet, register file always ready.
    wr_ready = 1'b1;
    push(EV_WR, 8'h03, d1);
    send_pkt(8'h03, d1, pkt_csum(8'h03, d1));
    tick(5);
    chk("post_write_valid_low", 64'(wr_valid), 64'd0);

    // Same packet held by back-pressure for 50 cycles.
    wr_ready = 1'b0;
    push(EV_WR, 8'h03, d1);
    send_pkt(8'h03, d1, pkt_csum(8'h03, d1));
    wait_valid("hold_valid_seen");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(wr_valid && wr_addr == 8'h03 && wr_data == d1)) bad++;
      tick(1);
    end
    chk("hold_stable_bad_cycles", 64'(bad), 64'd0);
    wr_ready = 1'b1;
    tick(1);
    chk("hold_release_valid_low", 64'(wr_valid), 64'd0);

    // Bad checksum, then a different good packet.
    push(EV_CSUM, 8'h00, 32'h0);
    send_pkt(8'h03, d1, 8'h28);
    tick(5);
    chk("csum_no_valid", 64'(wr_valid), 64'd0);
    push(EV_WR, 8'h7F, d2);
    send_pkt(8'h7F, d2, pkt_csum(8'h7F, d2));
    tick(5);

    // Framing error inside the data phase.
    push(EV_FRAME, 8'h00, 32'h0);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h78, 1'b0);
    tick(20);

    // Abandoned packet: A5 03 then silence.
    push(EV_TMO, 8'h00, 32'h0);
    send_byte(8'hA5);
    send_byte(8'h03);
    tick(170);
    chk("timeout_no_valid", 64'(wr_valid), 64'd0);

    // Overrun while a write is pending.
    wr_ready = 1'b0;
    send_pkt(8'h01, d2, pkt_csum(8'h01, d2));
    wait_valid("ovr_valid_seen");
    push(EV_OVR, 8'h00, 32'h0);
    send_byte(8'h00);
    chk("ovr_data_unchanged", {wr_valid, wr_addr, wr_data}, {23'h0, 1'b1, 8'h01, d2});
    push(EV_WR, 8'h01, d2);
    wr_ready = 1'b1;
    tick(3);

    // Short glitch on the line must be ignored.
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(30);

    // Reset in the middle of a packet.
    send_byte(8'hA5);
    send_byte(8'h03);
    rxd = 1'b0;
    tick(20);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midpkt_reset_outputs");
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(20);
    chk_idle_outputs("after_reset_outputs");
    push(EV_WR, 8'h04, d3);
    send_pkt(8'h04, d3, pkt_csum(8'h04, d3));

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
    tick(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
